// File: rtl/lab_io_pkg.sv
`default_nettype none
// ============================================================================
// Module : lab_io_pkg
// Brief  : Shared types and register map for the button/LED controller.
// Rev    : 1.0 - initial release
// ============================================================================
package lab_io_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_ON    = 2'b01,
        LED_BLINK = 2'b10,
        LED_PWM   = 2'b11
    } led_mode_e;

    localparam logic [2:0] ADDR_BTN_STATE = 3'd0;
    localparam logic [2:0] ADDR_BTN_EVT   = 3'd1;
    localparam logic [2:0] ADDR_IRQ_EN    = 3'd2;
    localparam logic [2:0] ADDR_LED_CFG0  = 3'd4;

    localparam int RELEASE_OFS = 8;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module : btn_debounce
// Brief  : Two-flop synchroniser plus stability counter with edge pulses.
// Rev    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_accept;

    // Pulses are combinational so the event flag lands on the same edge as the level.
    assign w_accept = (r_sync != r_level) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if ((r_sync == r_level) || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_level <= r_sync;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = w_accept & r_sync;
    assign o_release = w_accept & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/button_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module : button_led_ctrl
// Brief  : Debounced buttons with sticky events/IRQ and per-LED off/on/blink/PWM.
// Rev    : 1.0 - initial release
// ============================================================================
module button_led_ctrl
    import lab_io_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int NUM_LED         = 4,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_DIV       = 25000000,
    parameter int PWM_BITS        = 8
) (
    input  logic               io_systemClk,
    input  logic               io_systemReset,
    input  logic [NUM_BTN-1:0] butons,
    output logic [NUM_LED-1:0] leds,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [15:0]        cfg_wdata,
    output logic [15:0]        cfg_rdata,
    output logic               irq
);

    localparam int                   c_BLINK_W    = $clog2(BLINK_DIV + 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);

    logic [NUM_BTN-1:0]  w_raw;
    logic [NUM_BTN-1:0]  w_level;
    logic [NUM_BTN-1:0]  w_press;
    logic [NUM_BTN-1:0]  w_release;
    logic [NUM_BTN-1:0]  r_press_flg;
    logic [NUM_BTN-1:0]  r_rel_flg;
    logic [NUM_BTN-1:0]  r_press_en;
    logic [NUM_BTN-1:0]  r_rel_en;
    led_mode_e           r_mode [NUM_LED];
    logic [7:0]          r_duty [NUM_LED];
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                r_phase;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [NUM_LED-1:0]  w_leds;
    logic [NUM_LED-1:0]  r_leds;
    logic [15:0]         w_rdata;
    logic [15:0]         r_rdata;
    logic                r_irq;
    logic                w_wr_evt;
    logic                w_wr_en;
    logic                w_unused;

    assign w_raw    = (BTN_ACTIVE_LOW != 0) ? ~butons : butons;
    assign w_wr_evt = cfg_we && (cfg_addr == ADDR_BTN_EVT);
    assign w_wr_en  = cfg_we && (cfg_addr == ADDR_IRQ_EN);
    assign w_unused = &{1'b0, cfg_wdata};

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk       (io_systemClk),
                .rst       (io_systemReset),
                .i_raw     (w_raw[gi]),
                .o_level   (w_level[gi]),
                .o_press   (w_press[gi]),
                .o_release (w_release[gi])
            );
        end
    endgenerate

    always_ff @(posedge io_systemClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            r_press_flg <= '0;
            r_rel_flg   <= '0;
            r_press_en  <= '0;
            r_rel_en    <= '0;
            r_irq       <= 1'b0;
            r_rdata     <= '0;
            for (int i = 0; i < NUM_LED; i++) begin
                r_mode[i] <= LED_OFF;
                r_duty[i] <= '0;
            end
        end else begin
            // A new event pulse wins over a W1C of the same bit.
            r_press_flg <= (r_press_flg & ~(w_wr_evt ? cfg_wdata[NUM_BTN-1:0] : '0)) | w_press;
            r_rel_flg   <= (r_rel_flg & ~(w_wr_evt ? cfg_wdata[RELEASE_OFS +: NUM_BTN] : '0))
                           | w_release;
            if (w_wr_en) begin
                r_press_en <= cfg_wdata[NUM_BTN-1:0];
                r_rel_en   <= cfg_wdata[RELEASE_OFS +: NUM_BTN];
            end
            for (int i = 0; i < NUM_LED; i++) begin
                if (cfg_we && (cfg_addr == ADDR_LED_CFG0 + 3'(i))) begin
                    r_mode[i] <= led_mode_e'(cfg_wdata[1:0]);
                    r_duty[i] <= cfg_wdata[15:8];
                end
            end
            r_irq   <= |((r_press_flg & r_press_en) | (r_rel_flg & r_rel_en));
            r_rdata <= w_rdata;
        end
    end

    always_ff @(posedge io_systemClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_pwm_cnt   <= '0;
            r_leds      <= '0;
        end else begin
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_leds    <= w_leds;
        end
    end

    always_comb begin
        w_leds = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            case (r_mode[i])
                LED_OFF:   w_leds[i] = 1'b0;
                LED_ON:    w_leds[i] = 1'b1;
                LED_BLINK: w_leds[i] = r_phase;
                LED_PWM:   w_leds[i] = (r_pwm_cnt < r_duty[i][7 -: PWM_BITS]);
                default:   w_leds[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (cfg_addr)
            ADDR_BTN_STATE: w_rdata[NUM_BTN-1:0] = w_level;
            ADDR_BTN_EVT: begin
                w_rdata[NUM_BTN-1:0]             = r_press_flg;
                w_rdata[RELEASE_OFS +: NUM_BTN]  = r_rel_flg;
            end
            ADDR_IRQ_EN: begin
                w_rdata[NUM_BTN-1:0]             = r_press_en;
                w_rdata[RELEASE_OFS +: NUM_BTN]  = r_rel_en;
            end
            default: begin
                for (int i = 0; i < NUM_LED; i++) begin
                    if (cfg_addr == ADDR_LED_CFG0 + 3'(i)) begin
                        w_rdata = {r_duty[i], 6'd0, r_mode[i]};
                    end
                end
            end
        endcase
    end

    assign leds      = r_leds;
    assign cfg_rdata = r_rdata;
    assign irq       = r_irq;

endmodule
`default_nettype wire

// File: doc/button_led_ctrl.md
Name: button_led_ctrl

Overview:
- Parametrised successor to the board's bare 2-button / 4-LED pin path.
- Synchronises and debounces NUM_BTN raw buttons, and records sticky press/release events with an interrupt.
- Drives NUM_LED LEDs, each in its own mode: off, on, blink, or PWM brightness.
- Sits between the board pins (butons, leds) and the SoC's small register bus on io_systemClk.

Parameters:
NUM_BTN, 2, number of button inputs (1..8)
NUM_LED, 4, number of LED outputs (1..4)
BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed
DEBOUNCE_CYCLES, 500000, cycles a synchronised level must stay stable before it is accepted (>=2)
BLINK_DIV, 25000000, blink half-period in cycles (>=1)
PWM_BITS, 8, PWM counter and duty width (<=8)

Ports:
io_systemClk  in  1  system clock
io_systemReset  in  1  asynchronous active-high reset
butons  in  NUM_BTN  raw asynchronous button pins
leds  out  NUM_LED  LED drive, 1 = lit
cfg_we  in  1  register write strobe, one cycle
cfg_addr  in  3  register address for reads and writes
cfg_wdata  in  16  write data
cfg_rdata  out  16  read data, registered
irq  out  1  level interrupt

Behaviour:
- Reset (async assert, sync release):
  - leds=0, cfg_rdata=0, irq=0.
  - All registers and counters are 0; debounced state = released.
  - Reset during bounce discards partial counts.
- Input path:
  - 2-flop synchroniser per button; invert if BTN_ACTIVE_LOW, so internal 1 = pressed.
- Debounce, per button:
  - Counter clears whenever sync == debounced.
  - Otherwise it increments.
  - When the count reaches DEBOUNCE_CYCLES-1, debounced takes sync, the counter clears, and a 1-cycle press (0->1) or release (1->0) pulse is emitted.
  - Latency from pin edge to pulse = 2 + DEBOUNCE_CYCLES cycles.
  - Any glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Register map:
  - 0 BTN_STATE (RO): [NUM_BTN-1:0] debounced levels.
  - 1 BTN_EVT (W1C):
    - [NUM_BTN-1:0] sticky press flags.
    - [8+NUM_BTN-1:8] sticky release flags.
    - Set and W1C clear in the same cycle: set wins.
  - 2 IRQ_EN (RW): same bit layout as BTN_EVT.
  - 3: reserved.
  - 4+i LED_CFG[i] (RW):
    - [1:0] mode: 00 off, 01 on, 10 blink, 11 pwm.
    - [15:8] duty; only the upper PWM_BITS bits of the duty field are used.
  - Unimplemented bits, reserved addresses and LED index >= NUM_LED: read 0, writes ignored.
- Read timing: cfg_rdata = register at cfg_addr sampled on the previous cycle (1-cycle latency, no strobe).
- irq: registered OR of (BTN_EVT & IRQ_EN); asserts 1 cycle after the flag sets and deasserts 1 cycle after the clear.
- Blink:
  - One shared phase bit toggles every BLINK_DIV cycles, starting at 0 after reset.
  - All blink-mode LEDs are in phase; LED lit when phase = 1.
- PWM:
  - One free-running PWM_BITS counter.
  - LED lit when counter < duty.
  - duty 0 = always off; duty max = lit (2^PWM_BITS - 1) of 2^PWM_BITS cycles.
- leds are registered: a LED_CFG write takes effect on leds 2 cycles after the cfg_we cycle.
- Mode change mid-period takes effect immediately; counters are not reset.

Decomposition:
- Package lab_io_pkg:
  - LED mode enum (LED_OFF, LED_ON, LED_BLINK, LED_PWM).
  - Register address constants.
  - Event bit offset constant RELEASE_OFS = 8.
- Sub-module btn_debounce, one instance per button via generate:
  - Contains the synchroniser, counter and edge pulses.
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk, rst, raw, level, press, release.
- Top module holds the registers, blink/PWM timebases and LED muxing.

Test Plan:
- Reset:
  - Assert io_systemReset mid-operation with LED_CFG[0]=01 -> leds=0000 and irq=0 asynchronously.
  - After release, reads of addresses 0, 1, 2 and 4 all return 0.
- Debounce (DEBOUNCE_CYCLES=4):
  - butons[0] glitch low for 3 cycles -> BTN_STATE stays 0, no event.
  - Held low for 10 cycles -> BTN_STATE=0x0001 and BTN_EVT=0x0001 exactly 6 cycles after the edge.
- Interrupt and W1C:
  - IRQ_EN=0x0100, press then release button 0 -> irq rises only after release; BTN_EVT=0x0101.
  - Write 0x0100 to BTN_EVT -> BTN_EVT=0x0001, irq=0 next cycle.
- Set/clear collision: W1C of bit 0 in the same cycle a new press pulse occurs -> bit 0 remains 1.
- PWM (PWM_BITS=8):
  - LED_CFG[1]=0x4003 -> leds[1] high exactly 64 of every 256 cycles.
  - duty 0x00 -> never high; duty 0xFF -> high 255 of 256 cycles.
- Blink and unmapped (BLINK_DIV=5):
  - LED_CFG[2]=0x0002 -> leds[2] toggles every 5 cycles.
  - Write to address 3 -> ignored, reads 0.
  - With NUM_LED=2: write to address 6 -> ignored, reads 0.
